stn_cap: RTL and testbench

Parametrised STN panel capture engine: the successor to the fixed 4-bit/80-byte STN timing detector in `lcd_tg`. It samples an external STN panel bus (FPFRAME/FPLINE/FPSHIFT/FPDAT) and packs 4- or 8-bit beats into bytes. Each byte goes to the FIFO region or the RAM region of the shared capture buffer through a 2-entry write queue, so a slow `fifo_wrack` does not lose data. It reports overflow and frame status to the register block.

---
 rtl/lcd_tg_pkg.sv | 21 ++
 rtl/stn_cap_if.sv | 26 ++
 rtl/stn_wq.sv | 54 +++++
 rtl/stn_cap.sv | 194 +++++++++++++++++++
 tb/tb_stn_cap.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_tg_pkg.sv
// Shared STN capture constants and helpers.
// Defaults describe the 320x240 mono panel.
package lcd_tg_pkg;

  localparam int STN_DAT_W       = 4;
  localparam int STN_H_BYTES     = 80;
  localparam int STN_HBLANK_CLKS = 192;
  localparam int STN_SPLIT_LINE  = 120;
  localparam int STN_FIFO_DEPTH  = 1280;
  localparam int STN_RAM_END     = 6079;
  localparam int STN_ADDR_W      = 13;

  function automatic bit dat_w_ok(input int w);
    return (w == 4) || (w == 8);
  endfunction

  function automatic int bpb(input int w);
    return 8 / w;
  endfunction

endpackage

// File: rtl/stn_cap_if.sv
// Capture-buffer write port: request held until acked.
// The capture engine is the master.
interface stn_cap_if
  import lcd_tg_pkg::*;
#(
  parameter int ADDR_W = STN_ADDR_W
);
  logic              fifo_wrreq;
  logic              fifo_wrack;
  logic [ADDR_W-1:0] fifo_waddr;
  logic [7:0]        fifo_wdata;

  modport master (
    output fifo_wrreq,
    output fifo_waddr,
    output fifo_wdata,
    input  fifo_wrack
  );

  modport slave (
    input  fifo_wrreq,
    input  fifo_waddr,
    input  fifo_wdata,
    output fifo_wrack
  );
endinterface

// File: rtl/stn_wq.sv
// Two-entry write queue; entry 0 is always the head.
// Push on a full queue succeeds only alongside a pop.
module stn_wq #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst_x,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop;
  logic         do_push;
  logic [1:0]   slot;

  always_comb begin
    do_pop  = pop & (cnt_q != 2'd0);
    do_push = push & ((cnt_q != 2'd2) | do_pop);
    slot    = cnt_q - {1'b0, do_pop};
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    if (do_pop) ent0_d = ent1_q;
    if (do_push) begin
      if (slot == 2'd0) ent0_d = din;
      else              ent1_d = din;
    end
    cnt_d = cnt_q + {1'b0, do_push}
                  - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout  = ent0_q;
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/stn_cap.sv
// STN panel capture: sync, edge detect, pack beats
// into bytes and queue them for the capture buffer.
module stn_cap
  import lcd_tg_pkg::*;
#(
  parameter int DAT_W       = STN_DAT_W,
  parameter int H_BYTES     = STN_H_BYTES,
  parameter int HBLANK_CLKS = STN_HBLANK_CLKS,
  parameter int SPLIT_LINE  = STN_SPLIT_LINE,
  parameter int FIFO_DEPTH  = STN_FIFO_DEPTH,
  parameter int RAM_END     = STN_RAM_END,
  parameter int ADDR_W      = STN_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             cap_en,
  input  logic             stn_fpframe,
  input  logic             stn_fpline,
  input  logic             stn_fpshift,
  input  logic [DAT_W-1:0] stn_fpdat,
  stn_cap_if.master        wr,
  output logic             cap_ovf,
  output logic             frame_done,
  output logic [8:0]       line_cnt
);

  localparam int BPB  = bpb(DAT_W);
  localparam int BC_W = $clog2(H_BYTES + 1);
  localparam int HB_W = $clog2(HBLANK_CLKS + 2);
  localparam int QW   = ADDR_W + 8;

  if (!dat_w_ok(DAT_W)) begin : g_bad_dat_w
    $error("stn_cap: DAT_W must be 4 or 8");
  end

  logic [1:0]       frm_s_q, frm_s_d;
  logic [1:0]       lin_s_q, lin_s_d;
  logic [1:0]       shf_s_q, shf_s_d;
  logic [DAT_W-1:0] dat_s0_q, dat_s0_d;
  logic [DAT_W-1:0] dat_s1_q, dat_s1_d;

  logic              act_q, act_d;
  logic [8:0]        line_q, line_d;
  logic              beat_q, beat_d;
  logic [BC_W-1:0]   byte_q, byte_d;
  logic [HB_W-1:0]   blank_q, blank_d;
  logic [7:0]        asm_q, asm_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              ovf_q, ovf_d;
  logic              fd_q, fd_d;

  logic              frm_e, lin_e, shf_e;
  logic              shf_ok, beat_last;
  logic [7:0]        asm_sh;
  logic              push, pop;
  logic [ADDR_W-1:0] push_addr;
  logic [QW-1:0]     head;
  logic              q_full, q_empty;

  assign frm_e = frm_s_q[0] & ~frm_s_q[1];
  assign lin_e = ~lin_s_q[0] & lin_s_q[1];
  assign shf_e = ~shf_s_q[0] & shf_s_q[1];
  assign pop   = wr.fifo_wrreq & wr.fifo_wrack;

  always_comb begin
    frm_s_d  = {frm_s_q[0], stn_fpframe};
    lin_s_d  = {lin_s_q[0], stn_fpline};
    shf_s_d  = {shf_s_q[0], stn_fpshift};
    dat_s0_d = stn_fpdat;
    dat_s1_d = dat_s0_q;
  end

  always_comb begin
    act_d     = act_q;
    line_d    = line_q;
    beat_d    = beat_q;
    byte_d    = byte_q;
    asm_d     = asm_q;
    faddr_d   = faddr_q;
    raddr_d   = raddr_q;
    ovf_d     = ovf_q;
    fd_d      = 1'b0;
    push      = 1'b0;
    push_addr = faddr_q;
    blank_d   = (blank_q == '0) ? '0
                                : blank_q - 1'b1;
    shf_ok    = act_q && (blank_q == '0)
             && (byte_q < BC_W'(H_BYTES))
             && (line_q != 9'd511);
    beat_last = (beat_q == 1'(BPB - 1));
    asm_sh    = 8'({asm_q, dat_s1_q});
    priority case (1'b1)
      frm_e: begin
        line_d  = 9'd0;
        beat_d  = 1'b0;
        byte_d  = '0;
        faddr_d = '0;
        raddr_d = ADDR_W'(FIFO_DEPTH);
        ovf_d   = 1'b0;
        act_d   = cap_en;
        fd_d    = act_q;
      end
      lin_e: begin
        beat_d  = 1'b0;
        byte_d  = '0;
        blank_d = HB_W'(HBLANK_CLKS);
        if (act_q && blank_q == '0
            && line_q != 9'd511)
          line_d = line_q + 9'd1;
      end
      (shf_e && shf_ok): begin
        asm_d = asm_sh;
        if (beat_last) begin
          beat_d = 1'b0;
          byte_d = byte_q + 1'b1;
          push   = 1'b1;
          if (line_q < 9'(SPLIT_LINE)) begin
            push_addr = faddr_q;
            faddr_d   =
              (faddr_q == ADDR_W'(FIFO_DEPTH - 1))
              ? '0 : faddr_q + 1'b1;
          end else begin
            push_addr = raddr_q;
            raddr_d   =
              (raddr_q == ADDR_W'(RAM_END))
              ? ADDR_W'(FIFO_DEPTH)
              : raddr_q + 1'b1;
          end
          // dropped byte still consumes its address
          if (q_full && !pop) ovf_d = 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      frm_s_q  <= '0;
      lin_s_q  <= '0;
      shf_s_q  <= '0;
      dat_s0_q <= '0;
      dat_s1_q <= '0;
      act_q    <= 1'b0;
      line_q   <= 9'd0;
      beat_q   <= 1'b0;
      byte_q   <= '0;
      blank_q  <= '0;
      asm_q    <= 8'd0;
      faddr_q  <= '0;
      raddr_q  <= ADDR_W'(FIFO_DEPTH);
      ovf_q    <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      frm_s_q  <= frm_s_d;
      lin_s_q  <= lin_s_d;
      shf_s_q  <= shf_s_d;
      dat_s0_q <= dat_s0_d;
      dat_s1_q <= dat_s1_d;
      act_q    <= act_d;
      line_q   <= line_d;
      beat_q   <= beat_d;
      byte_q   <= byte_d;
      blank_q  <= blank_d;
      asm_q    <= asm_d;
      faddr_q  <= faddr_d;
      raddr_q  <= raddr_d;
      ovf_q    <= ovf_d;
      fd_q     <= fd_d;
    end
  end

  stn_wq #(.W(QW)) u_wq (
    .clk   (clk),
    .rst_x (rst_x),
    .push  (push),
    .pop   (pop),
    .din   ({push_addr, asm_sh}),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty)
  );

  assign wr.fifo_wrreq = ~q_empty;
  assign wr.fifo_waddr = head[QW-1:8];
  assign wr.fifo_wdata = head[7:0];
  assign cap_ovf       = ovf_q;
  assign frame_done    = fd_q;
  assign line_cnt      = line_q;

endmodule

// File: tb/tb_stn_cap.sv
// Randomised panel stimulus against a byte-level model;
// expected buffer writes flow through a scoreboard queue.
module tb_stn_cap;

  localparam int DW    = 4;
  localparam int HB    = 4;
  localparam int HBLK  = 24;
  localparam int SPLIT = 2;
  localparam int FD    = 4;
  localparam int RE    = 9;
  localparam int AW    = 13;

  logic          clk = 1'b0;
  logic          rst_x = 1'b0;
  logic          cap_en = 1'b0;
  logic          fpframe = 1'b0;
  logic          fpline = 1'b0;
  logic          fpshift = 1'b0;
  logic [DW-1:0] fpdat = '0;
  logic          cap_ovf;
  logic          frame_done;
  logic [8:0]    line_cnt;

  stn_cap_if #(.ADDR_W(AW)) wr();

  stn_cap #(
    .DAT_W(DW), .H_BYTES(HB), .HBLANK_CLKS(HBLK),
    .SPLIT_LINE(SPLIT), .FIFO_DEPTH(FD),
    .RAM_END(RE), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_x(rst_x), .cap_en(cap_en),
    .stn_fpframe(fpframe), .stn_fpline(fpline),
    .stn_fpshift(fpshift), .stn_fpdat(fpdat),
    .wr(wr), .cap_ovf(cap_ovf),
    .frame_done(frame_done), .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t sb[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  fd_cnt = 0;
  int  stall = 0;
  bit  hold_ack = 1'b0;

  bit         m_act, m_blank, m_ovf;
  int         m_line, m_byte, m_beat;
  int         m_fa, m_ra, m_fd, m_held;
  logic [7:0] m_asm;

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, got, want);
  endtask

  // ack driver and write monitor
  always @(negedge clk) begin
    logic ack;
    wr_t  e;
    if (!rst_x || hold_ack) ack = 1'b0;
    else if (stall >= 4)    ack = 1'b1;
    else ack = ($urandom_range(0, 3) != 0);
    stall = ack ? 0 : stall + 1;
    wr.fifo_wrack = ack;
    if (rst_x && wr.fifo_wrreq && ack) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got %0h/%0h want none",
                 wr.fifo_waddr, wr.fifo_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(wr.fifo_waddr), 32'(e.a));
        chk("wr_data", 32'(wr.fifo_wdata), 32'(e.d));
      end
    end
    if (frame_done) fd_cnt++;
  end

  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_act = 0; m_blank = 0; m_ovf = 0;
    m_line = 0; m_byte = 0; m_beat = 0;
    m_fa = 0; m_ra = FD; m_held = 0;
    m_asm = 8'h00;
  endtask

  task automatic frame(bit en);
    cap_en = en;
    fpframe = 1'b1;
    wait_clk(3);
    fpframe = 1'b0;
    wait_clk(3);
    if (m_act) m_fd++;
    m_act = en;
    m_line = 0; m_byte = 0; m_beat = 0;
    m_fa = 0; m_ra = FD; m_ovf = 0;
    chk("frame_done_cnt", 32'(fd_cnt), 32'(m_fd));
    chk("frame_ovf", 32'(cap_ovf), 32'(m_ovf));
    chk("frame_line_cnt", 32'(line_cnt), 32'd0);
  endtask

  task automatic line();
    fpline = 1'b1;
    wait_clk(3);
    fpline = 1'b0;
    wait_clk(3);
    if (m_act && !m_blank && m_line < 511) m_line++;
    m_blank = 1; m_byte = 0; m_beat = 0;
    chk("line_cnt", 32'(line_cnt), 32'(m_line));
  endtask

  task automatic settle();
    wait_clk(HBLK + 6);
    m_blank = 0;
  endtask

  task automatic beat(logic [DW-1:0] d);
    int  a;
    wr_t e;
    fpdat = d;
    fpshift = 1'b1;
    wait_clk(4);
    if (m_act && !m_blank && m_byte < HB
        && m_line < 511) begin
      m_asm = {m_asm[3:0], d};
      m_beat++;
      if (m_beat == 2) begin
        m_beat = 0;
        m_byte++;
        if (m_line < SPLIT) begin
          a = m_fa; m_fa = (m_fa + 1) % FD;
        end else begin
          a = m_ra; m_ra = (m_ra == RE) ? FD : m_ra + 1;
        end
        if (hold_ack && m_held >= 2) m_ovf = 1;
        else begin
          e.a = AW'(a); e.d = m_asm;
          sb.push_back(e);
        end
        if (hold_ack) m_held++;
      end
    end
    fpshift = 1'b0;
    wait_clk(4);
  endtask

  task automatic put_byte(logic [7:0] b);
    beat(b[7:4]);
    beat(b[3:0]);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      wait_clk(1); t++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               sb.size());
    end
    wait_clk(3);
    chk("queue_idle", 32'(wr.fifo_wrreq), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    m_fd = 0;
    wait_clk(3);
    chk("rst_wrreq", 32'(wr.fifo_wrreq), 32'd0);
    chk("rst_waddr", 32'(wr.fifo_waddr), 32'd0);
    chk("rst_wdata", 32'(wr.fifo_wdata), 32'd0);
    chk("rst_ovf", 32'(cap_ovf), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_line", 32'(line_cnt), 32'd0);
    rst_x = 1'b1;
    wait_clk(3);

    // disabled frame, then first enabled frame
    frame(1'b0);
    put_byte(8'h3C);
    line(); settle();
    put_byte(8'hC3);
    drain();
    frame(1'b1);
    put_byte(8'hA5);
    for (int i = 0; i < 4; i++)
      put_byte(8'($urandom_range(0, 255)));
    line(); settle();
    put_byte(8'h11);
    drain();
    frame(1'b1);

    // blanking and a line edge inside blanking
    line();
    beat(4'h1); beat(4'h2);
    settle();
    drain();
    line();
    line();
    settle();
    put_byte(8'h42);
    drain();

    // backpressure
    frame(1'b1);
    hold_ack = 1'b1;
    m_held = 0;
    for (int i = 0; i < 3; i++) begin
      put_byte(8'(8'h60 + i));
      chk("held_addr", 32'(wr.fifo_waddr), 32'(sb[0].a));
      chk("held_req", 32'(wr.fifo_wrreq), 32'd1);
    end
    chk("ovf_set", 32'(cap_ovf), 32'(m_ovf));
    hold_ack = 1'b0;
    wait_clk(20);
    put_byte(8'h99);
    drain();
    chk("ovf_sticky", 32'(cap_ovf), 32'(m_ovf));
    frame(1'b1);

    // split/wrap: four full lines
    for (int l = 0; l < 4; l++) begin
      if (l > 0) begin line(); settle(); end
      for (int b = 0; b < HB; b++)
        put_byte(8'($urandom_range(0, 255)));
    end
    drain();

    // random frames
    for (int f = 0; f < 6; f++) begin
      frame($urandom_range(0, 3) != 0);
      for (int l = 0; l < 2 + $urandom_range(0, 4); l++) begin
        if (l > 0) begin line(); settle(); end
        for (int b = 0; b < $urandom_range(0, 5); b++)
          put_byte(8'($urandom_range(0, 255)));
      end
    end
    drain();

    // reset mid-line with a write pending
    frame(1'b1);
    line(); settle();
    hold_ack = 1'b1;
    m_held = 0;
    put_byte(8'h77);
    beat(4'h1);
    rst_x = 1'b0;
    #1;
    chk("mrst_wrreq", 32'(wr.fifo_wrreq), 32'd0);
    chk("mrst_waddr", 32'(wr.fifo_waddr), 32'd0);
    chk("mrst_wdata", 32'(wr.fifo_wdata), 32'd0);
    chk("mrst_line", 32'(line_cnt), 32'd0);
    chk("mrst_ovf", 32'(cap_ovf), 32'd0);
    sb.delete();
    model_reset();
    hold_ack = 1'b0;
    wait_clk(2);
    rst_x = 1'b1;
    wait_clk(3);
    frame(1'b1);
    put_byte(8'h5A);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
